// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Opcodes, field encodings, control-word layout and FSM states
//            shared by the RV32I(M) decode-stage control path.
// Revision : 1.0
// ============================================================================
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_BRCMP = 2'b10;
    localparam logic [1:0] ALU_FUNCT = 2'b11;

    // Control word: seven single-bit flags followed by the three encoded fields
    localparam int CW_W          = 14;
    localparam int CW_REGWRITE   = 0;
    localparam int CW_ALUSRC     = 1;
    localparam int CW_MEMWRITE   = 2;
    localparam int CW_BRANCH     = 3;
    localparam int CW_JUMP       = 4;
    localparam int CW_JALR       = 5;
    localparam int CW_PCREL      = 6;
    localparam int CW_IMMSRC_LSB = 7;
    localparam int CW_RESSRC_LSB = 10;
    localparam int CW_ALUOP_LSB  = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage : riscv_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_comb
// Purpose  : Combinational RV32I(M) opcode/funct decoder producing the
//            control word plus M-unit, divide and illegal flags.
// Revision : 1.0
// ============================================================================
module ctrl_decode_comb
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output ctrl_word_t  cw,
    output logic        muldiv,
    output logic        is_div,
    output logic        illegal
);

    ctrl_word_t raw_cw;
    logic       raw_muldiv;
    logic       raw_illegal;

    always_comb begin
        raw_cw      = '0;
        raw_muldiv  = 1'b0;
        raw_illegal = 1'b0;
        unique case (op)
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    raw_cw[CW_REGWRITE]               = 1'b1;
                    raw_cw[CW_ALUSRC]                 = 1'b1;
                    raw_cw[CW_IMMSRC_LSB +: 3]        = IMM_I;
                    raw_cw[CW_RESSRC_LSB +: 2]        = RES_MEM;
                    raw_cw[CW_ALUOP_LSB +: 2]         = ALU_ADD;
                end else begin
                    raw_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    raw_cw[CW_MEMWRITE]               = 1'b1;
                    raw_cw[CW_ALUSRC]                 = 1'b1;
                    raw_cw[CW_IMMSRC_LSB +: 3]        = IMM_S;
                    raw_cw[CW_ALUOP_LSB +: 2]         = ALU_ADD;
                end else begin
                    raw_illegal = 1'b1;
                end
            end
            OP_RTYPE: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    raw_cw[CW_REGWRITE]               = 1'b1;
                    raw_cw[CW_ALUOP_LSB +: 2]         = ALU_FUNCT;
                end else if (funct7 == F7_MULDIV && ENABLE_M) begin
                    raw_cw[CW_REGWRITE]               = 1'b1;
                    raw_cw[CW_ALUOP_LSB +: 2]         = ALU_FUNCT;
                    raw_muldiv                        = 1'b1;
                end else begin
                    raw_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                unique case (funct3)
                    3'b000: begin
                        raw_cw[CW_BRANCH]             = 1'b1;
                        raw_cw[CW_IMMSRC_LSB +: 3]    = IMM_B;
                        raw_cw[CW_ALUOP_LSB +: 2]     = ALU_SUB;
                    end
                    3'b001, 3'b100, 3'b101, 3'b110, 3'b111: begin
                        raw_cw[CW_BRANCH]             = 1'b1;
                        raw_cw[CW_IMMSRC_LSB +: 3]    = IMM_B;
                        raw_cw[CW_ALUOP_LSB +: 2]     = ALU_BRCMP;
                    end
                    default: raw_illegal = 1'b1;
                endcase
            end
            OP_IALU: begin
                raw_cw[CW_REGWRITE]                   = 1'b1;
                raw_cw[CW_ALUSRC]                     = 1'b1;
                raw_cw[CW_IMMSRC_LSB +: 3]            = IMM_I;
                raw_cw[CW_ALUOP_LSB +: 2]             = ALU_FUNCT;
            end
            OP_JAL: begin
                raw_cw[CW_REGWRITE]                   = 1'b1;
                raw_cw[CW_JUMP]                       = 1'b1;
                raw_cw[CW_IMMSRC_LSB +: 3]            = IMM_J;
                raw_cw[CW_RESSRC_LSB +: 2]            = RES_PC4;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    raw_cw[CW_REGWRITE]               = 1'b1;
                    raw_cw[CW_ALUSRC]                 = 1'b1;
                    raw_cw[CW_JUMP]                   = 1'b1;
                    raw_cw[CW_JALR]                   = 1'b1;
                    raw_cw[CW_IMMSRC_LSB +: 3]        = IMM_I;
                    raw_cw[CW_RESSRC_LSB +: 2]        = RES_PC4;
                end else begin
                    raw_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                raw_cw[CW_REGWRITE]                   = 1'b1;
                raw_cw[CW_ALUSRC]                     = 1'b1;
                raw_cw[CW_IMMSRC_LSB +: 3]            = IMM_U;
                raw_cw[CW_RESSRC_LSB +: 2]            = RES_IMM;
            end
            OP_AUIPC: begin
                raw_cw[CW_REGWRITE]                   = 1'b1;
                raw_cw[CW_ALUSRC]                     = 1'b1;
                raw_cw[CW_PCREL]                      = 1'b1;
                raw_cw[CW_IMMSRC_LSB +: 3]            = IMM_U;
                raw_cw[CW_ALUOP_LSB +: 2]             = ALU_ADD;
            end
            default: raw_illegal = 1'b1;
        endcase
    end

    // An illegal instruction must present a clean all-zero word to Execute
    assign illegal = raw_illegal;
    assign cw      = raw_illegal ? '0 : raw_cw;
    assign muldiv  = raw_muldiv & ~raw_illegal;
    assign is_div  = muldiv & funct3[2];

endmodule : ctrl_decode_comb
`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_stage
// Purpose  : Registered ID/EX control decoder with stall/flush handling and a
//            multi-cycle busy FSM that holds divides in Execute.
// Revision : 1.0
// ============================================================================
module ctrl_decode_stage
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_M   = 1'b1,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid_d,
    input  logic [31:0] instr_d,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        ready_d,
    output logic        muldiv_busy,
    output logic        valid_e,
    output logic        RegWriteE,
    output logic        ALUSrcE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        JumpE,
    output logic        JalrE,
    output logic        PcRelE,
    output logic        MulDivE,
    output logic        IllegalE,
    output logic [2:0]  ImmSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [1:0]  ALUOpE
);

    ctrl_word_t dec_cw;
    logic       dec_muldiv;
    logic       dec_is_div;
    logic       dec_illegal;
    logic       accept;
    logic       unused_instr_bits;

    logic [0:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic       valid_q, valid_d;
    ctrl_word_t cw_q, cw_d;
    logic       muldiv_q, muldiv_d;
    logic       illegal_q, illegal_d;

    ctrl_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .op      (instr_d[6:0]),
        .funct3  (instr_d[14:12]),
        .funct7  (instr_d[31:25]),
        .cw      (dec_cw),
        .muldiv  (dec_muldiv),
        .is_div  (dec_is_div),
        .illegal (dec_illegal)
    );

    assign unused_instr_bits = ^{instr_d[24:15], instr_d[11:7]};

    assign accept = instr_valid_d & ready_d & ~stall_e & ~flush_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BUSY counts down unconditionally; only a flush can cut it short
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_e) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                state_d = ST_IDLE;
            end
        end else if (accept && dec_is_div) begin
            state_d = ST_BUSY;
            cnt_d   = 8'(DIV_CYCLES - 1);
        end
    end

    always_comb begin
        ready_d     = (state_q == ST_IDLE);
        muldiv_busy = (state_q == ST_BUSY);
    end

    always_comb begin
        valid_d   = 1'b0;
        cw_d      = '0;
        muldiv_d  = 1'b0;
        illegal_d = 1'b0;
        if (flush_e) begin
            valid_d   = 1'b0;
        end else if (stall_e || state_q == ST_BUSY) begin
            valid_d   = valid_q;
            cw_d      = cw_q;
            muldiv_d  = muldiv_q;
            illegal_d = illegal_q;
        end else if (accept) begin
            valid_d   = 1'b1;
            cw_d      = dec_cw;
            muldiv_d  = dec_muldiv;
            illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            cw_q      <= '0;
            muldiv_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            cw_q      <= cw_d;
            muldiv_q  <= muldiv_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_e    = valid_q;
    assign RegWriteE  = cw_q[CW_REGWRITE];
    assign ALUSrcE    = cw_q[CW_ALUSRC];
    assign MemWriteE  = cw_q[CW_MEMWRITE];
    assign BranchE    = cw_q[CW_BRANCH];
    assign JumpE      = cw_q[CW_JUMP];
    assign JalrE      = cw_q[CW_JALR];
    assign PcRelE     = cw_q[CW_PCREL];
    assign ImmSrcE    = cw_q[CW_IMMSRC_LSB +: 3];
    assign ResultSrcE = cw_q[CW_RESSRC_LSB +: 2];
    assign ALUOpE     = cw_q[CW_ALUOP_LSB +: 2];
    assign MulDivE    = muldiv_q;
    assign IllegalE   = illegal_q;

endmodule : ctrl_decode_stage
`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_decode_stage
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a behavioural model, for M-enabled and M-disabled builds.
// Revision : 1.0
// ============================================================================
module tb_ctrl_decode_stage;

    localparam int DIVC = 4;

    typedef struct packed {
        logic       valid;
        logic       regw;
        logic       alusrc;
        logic       memw;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       pcrel;
        logic       muldiv;
        logic       illegal;
        logic [2:0] imm;
        logic [1:0] res;
        logic [1:0] aluop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_d;
    logic [31:0] instr_d;
    logic        stall_e;
    logic        flush_e;

    logic        ready_m, busy_m, valid_m, regw_m, alusrc_m, memw_m, br_m, jmp_m, jalr_m, pcrel_m, md_m, ill_m;
    logic [2:0]  imm_m;
    logic [1:0]  res_m, aluop_m;
    logic        ready_n, busy_n, valid_n, regw_n, alusrc_n, memw_n, br_n, jmp_n, jalr_n, pcrel_n, md_n, ill_n;
    logic [2:0]  imm_n;
    logic [1:0]  res_n, aluop_n;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        exp_w [2];
    int          busy_left [2];
    logic [6:0]  op_pool [10];

    always #5 clk = ~clk;

    ctrl_decode_stage #(.ENABLE_M(1'b1), .DIV_CYCLES(DIVC)) u_dut_m (
        .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .instr_d(instr_d),
        .stall_e(stall_e), .flush_e(flush_e), .ready_d(ready_m), .muldiv_busy(busy_m),
        .valid_e(valid_m), .RegWriteE(regw_m), .ALUSrcE(alusrc_m), .MemWriteE(memw_m),
        .BranchE(br_m), .JumpE(jmp_m), .JalrE(jalr_m), .PcRelE(pcrel_m), .MulDivE(md_m),
        .IllegalE(ill_m), .ImmSrcE(imm_m), .ResultSrcE(res_m), .ALUOpE(aluop_m)
    );

    ctrl_decode_stage #(.ENABLE_M(1'b0), .DIV_CYCLES(DIVC)) u_dut_n (
        .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .instr_d(instr_d),
        .stall_e(stall_e), .flush_e(flush_e), .ready_d(ready_n), .muldiv_busy(busy_n),
        .valid_e(valid_n), .RegWriteE(regw_n), .ALUSrcE(alusrc_n), .MemWriteE(memw_n),
        .BranchE(br_n), .JumpE(jmp_n), .JalrE(jalr_n), .PcRelE(pcrel_n), .MulDivE(md_n),
        .IllegalE(ill_n), .ImmSrcE(imm_n), .ResultSrcE(res_n), .ALUOpE(aluop_n)
    );

    wire exp_t obs_m = '{valid_m, regw_m, alusrc_m, memw_m, br_m, jmp_m, jalr_m, pcrel_m,
                         md_m, ill_m, imm_m, res_m, aluop_m};
    wire exp_t obs_n = '{valid_n, regw_n, alusrc_n, memw_n, br_n, jmp_n, jalr_n, pcrel_n,
                         md_n, ill_n, imm_n, res_n, aluop_n};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction meaning, written mnemonic by mnemonic from the ISA table
    function automatic exp_t model_decode(input logic [31:0] ins, input bit m_en);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e  = '0;
        ok = 1'b1;
        if (op == 7'h03 && f3 == 3'd2) begin
            e.regw = 1; e.alusrc = 1; e.imm = 3'd0; e.res = 2'd1;
        end else if (op == 7'h23 && f3 == 3'd2) begin
            e.memw = 1; e.alusrc = 1; e.imm = 3'd1;
        end else if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
            e.regw = 1; e.aluop = 2'd3;
        end else if (op == 7'h33 && f7 == 7'h01 && m_en) begin
            e.regw = 1; e.aluop = 2'd3; e.muldiv = 1;
        end else if (op == 7'h63 && f3 == 3'd0) begin
            e.branch = 1; e.imm = 3'd2; e.aluop = 2'd1;
        end else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            e.branch = 1; e.imm = 3'd2; e.aluop = 2'd2;
        end else if (op == 7'h13) begin
            e.regw = 1; e.alusrc = 1; e.imm = 3'd0; e.aluop = 2'd3;
        end else if (op == 7'h6F) begin
            e.regw = 1; e.jump = 1; e.imm = 3'd3; e.res = 2'd2;
        end else if (op == 7'h67 && f3 == 3'd0) begin
            e.regw = 1; e.alusrc = 1; e.jump = 1; e.jalr = 1; e.imm = 3'd0; e.res = 2'd2;
        end else if (op == 7'h37) begin
            e.regw = 1; e.alusrc = 1; e.imm = 3'd4; e.res = 2'd3;
        end else if (op == 7'h17) begin
            e.regw = 1; e.alusrc = 1; e.pcrel = 1; e.imm = 3'd4;
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            e = '0;
            e.illegal = 1;
        end
        e.valid = 1;
        return e;
    endfunction

    function automatic bit model_is_div(input logic [31:0] ins, input bit m_en);
        return m_en && ins[6:0] == 7'h33 && ins[31:25] == 7'h01 && ins[14];
    endfunction

    task automatic step(input bit rst_i, input bit v, input logic [31:0] ins,
                        input bit st, input bit fl);
        reset         = rst_i;
        instr_valid_d = v;
        instr_d       = ins;
        stall_e       = st;
        flush_e       = fl;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst_i || fl) begin
                exp_w[k]     = '0;
                busy_left[k] = 0;
            end else if (st || busy_left[k] > 0) begin
                if (busy_left[k] > 0) busy_left[k]--;
            end else if (v) begin
                exp_w[k] = model_decode(ins, k == 0);
                if (model_is_div(ins, k == 0)) busy_left[k] = DIVC - 1;
            end else begin
                exp_w[k] = '0;
            end
        end
        #1;
        check_val("word_m", 32'(obs_m), 32'(exp_w[0]));
        check_val("word_n", 32'(obs_n), 32'(exp_w[1]));
        check_val("fsm_m", {30'd0, busy_m, ready_m}, {30'd0, busy_left[0] > 0, busy_left[0] == 0});
        check_val("fsm_n", {30'd0, busy_n, ready_n}, {30'd0, busy_left[1] > 0, busy_left[1] == 0});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = op_pool[$urandom_range(0, 9)];
        case ($urandom_range(0, 2))
            0:       f3 = 3'b000;
            1:       f3 = 3'b010;
            default: f3 = 3'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), op};
    endfunction

    initial begin
        int busy_cnt;
        op_pool = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
        exp_w[0] = '0; exp_w[1] = '0;
        busy_left[0] = 0; busy_left[1] = 0;

        step(1, 0, 32'h0, 0, 0);
        step(1, 1, 32'h00002083, 0, 0);
        check_val("rst_valid", {31'd0, valid_m}, 32'd0);
        check_val("rst_ready", {31'd0, ready_m}, 32'd1);

        step(0, 1, 32'h00002083, 0, 0);
        check_val("lw_bits", {27'd0, valid_m, regw_m, alusrc_m, res_m}, {27'd0, 1'b1, 1'b1, 1'b1, 2'b01});
        check_val("lw_imm", {29'd0, imm_m}, 32'd0);

        step(0, 1, 32'h00000063, 0, 0);
        check_val("beq_aluop", {30'd0, aluop_m}, 32'd1);
        step(0, 1, 32'h00006063, 0, 0);
        check_val("bltu_aluop", {30'd0, aluop_m}, 32'd2);
        step(0, 1, 32'h00002063, 0, 0);
        check_val("br010_ill", {29'd0, ill_m, regw_m, br_m}, {29'd0, 3'b100});

        step(0, 1, 32'h0220C1B3, 0, 0);
        check_val("div_md", {30'd0, md_m, ill_n}, {30'd0, 2'b11});
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            busy_cnt += int'(busy_m);
            step(0, 1, 32'h123452B7, 0, 0);
        end
        check_val("div_busy_len", 32'(busy_cnt), 32'd3);
        check_val("lui_fields", {27'd0, imm_m, res_m}, {27'd0, 3'b100, 2'b11});

        step(0, 1, 32'h0220C1B3, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 1);
        check_val("abort", {30'd0, valid_m, ready_m}, {30'd0, 2'b01});

        step(0, 1, 32'h0220C1B3, 0, 1);
        check_val("flush_accept", {30'd0, busy_m, valid_m}, 32'd0);

        step(0, 1, 32'h00002083, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h00000063, 1, 0);
        check_val("stall_hold", {30'd0, valid_m, regw_m}, {30'd0, 2'b11});
        step(0, 1, 32'h00000063, 1, 1);
        check_val("stall_flush", {31'd0, valid_m}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 8,
                 rand_instr(),
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 7);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ctrl_decode_stage
`default_nettype wire

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered control decoder for the pipelined RV32I core, with optional M-extension support. It sits between the IF/ID and ID/EX pipeline registers, decodes the full opcode/funct3/funct7 of the instruction in Decode, and registers the control word into the Execute stage. It replaces X-default decoding with explicit illegal-instruction flagging, handles stall and flush, and runs a multi-cycle busy FSM for divide instructions.

## Interface
Parameters:
- ENABLE_M, 1: when 1, decode M-extension R-type instructions (funct7=0000001); when 0, treat them as illegal.
- DIV_CYCLES, 32: Execute occupancy of DIV/DIVU/REM/REMU, in cycles. Legal range is 2..255.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- instr_valid_d  in  1  Decode holds a real instruction
- instr_d  in  32  instruction; op=[6:0], funct3=[14:12], funct7=[31:25]
- stall_e  in  1  hazard unit: hold the ID/EX control register
- flush_e  in  1  hazard unit: load a bubble
- ready_d  out  1  decoder can accept; equals (state==IDLE)
- muldiv_busy  out  1  equals (state==BUSY); the hazard unit stalls F/D on it
- valid_e  out  1  Execute control word is live
- RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  out  1 each  same meaning as in the existing control path
- JalrE  out  1  jump target comes from rs1+imm
- PcRelE  out  1  auipc; ALU A operand is PC
- MulDivE  out  1  route to the M unit
- IllegalE  out  1  illegal instruction; the trap unit consumes it
- ImmSrcE  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- ResultSrcE  out  2  00=ALU, 01=mem, 10=PC+4, 11=imm/U
- ALUOpE  out  2  00=add, 01=sub, 10=branch-compare, 11=funct-decoded

## Operation
Decode is combinational on instr_d. No output is ever X.
- lw (0000011, funct3=010): RegWrite, ImmSrc=I, ALUSrc, ResultSrc=01, ALUOp=00.
- sw (0100011, funct3=010): MemWrite, ImmSrc=S, ALUSrc, ALUOp=00.
- R-type (0110011):
  - funct7=0000000 or 0100000: RegWrite, ALUOp=11.
  - funct7=0000001 with ENABLE_M=1: additionally MulDiv.
- Branch (1100011):
  - funct3=000 (beq): Branch, ImmSrc=B, ALUOp=01.
  - funct3 in {001,100,101,110,111}: Branch, ImmSrc=B, ALUOp=10.
- I-ALU (0010011): RegWrite, ImmSrc=I, ALUSrc, ALUOp=11.
- jal (1101111): RegWrite, ImmSrc=J, Jump, ResultSrc=10.
- jalr (1100111, funct3=000): RegWrite, ImmSrc=I, ALUSrc, Jump, Jalr, ResultSrc=10.
- lui (0110111): RegWrite, ImmSrc=U, ALUSrc, ResultSrc=11.
- auipc (0010111): RegWrite, ImmSrc=U, ALUSrc, PcRel, ALUOp=00.
- Anything else is illegal: unknown op, branch funct3 010/011, load/store funct3 other than 010, jalr funct3 other than 000, any other funct7, or M-ext with ENABLE_M=0.
  - The illegal control word has all fields 0 except IllegalE=1.
  - valid_e=1, so the trap unit sees it.

FSM has two states, IDLE and BUSY, plus an 8-bit down-counter cnt.
- accept = instr_valid_d & ready_d & ~stall_e & ~flush_e.
- IDLE→BUSY: on accept of a legal M-ext instruction with funct3[2]=1. cnt loads DIV_CYCLES-1.
- BUSY: cnt decrements every cycle, regardless of stall_e.
- BUSY→IDLE: when cnt==1 the next state is IDLE; cnt reaches 0 on that edge.
- MUL (funct3[2]=0) is single-cycle and does not enter BUSY.

ID/EX register update, in priority order:
1. reset: all outputs 0; state IDLE; cnt 0.
2. flush_e: bubble (all control and valid_e = 0). If in BUSY, go to IDLE and clear cnt (abort).
3. stall_e, or state==BUSY: hold the register.
4. accept: load the decoded word; valid_e=1.
5. Otherwise: bubble.

## Timing
- Reset values: valid_e=0, every control output 0, ready_d=1, muldiv_busy=0.
- Latency is 1 cycle: instr_d is accepted at edge N and the control word is visible after edge N.
- ready_d and muldiv_busy are Moore outputs decoded from state only.
- A divide holds its word in E for exactly DIV_CYCLES cycles.
  - ready_d is low for DIV_CYCLES-1 cycles starting the cycle after acceptance.
  - The next instruction can be accepted in the cycle state returns to IDLE.
- stall_e and flush_e asserted together: flush wins.
- flush_e on the acceptance edge of a divide: bubble; the FSM stays in IDLE.
- instr_valid_d low with no stall: bubble; state is unaffected.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode localparams;
  - ImmSrc, ResultSrc and ALUOp encodings;
  - the control-word width (14) and field offsets;
  - FSM state encoding.
- One sub-module, ctrl_decode_comb: a purely combinational instr→{control word, is_div, illegal} decoder.
- The top module holds the FSM, cnt and the ID/EX register.

## Test plan
- Reset, then lw x1,0(x0) = 0x00002083 with valid → next cycle valid_e=1, RegWriteE=1, ResultSrcE=01, ALUSrcE=1, ImmSrcE=000.
- 0x00000063 (beq), then 0x00006063 (bltu), then 0x00002063 → ALUOpE 01, then 10, then IllegalE=1 with RegWriteE=0, BranchE=0.
- div x3,x1,x2 = 0x0220C1B3 with DIV_CYCLES=4 → MulDivE=1; muldiv_busy high 3 cycles; E held 4 cycles; the following lui 0x123452B7 appears with ImmSrcE=100, ResultSrcE=11.
- Same div with ENABLE_M=0 → IllegalE=1, muldiv_busy never asserts.
- Divide accepted, flush_e on the 2nd BUSY cycle → next cycle valid_e=0, ready_d=1, state IDLE.
- stall_e held 3 cycles while valid_e=1 → E outputs unchanged; stall_e+flush_e together → bubble.
